// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the multi-channel push-button conditioner.
//   btn_state_t    : per-channel debounce FSM state.
//   rep_ctr_width  : width of the auto-repeat counter so that it can hold the
//                    larger of the first-repeat delay and the repeat period.
// -----------------------------------------------------------------------------
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      PRESSING  = 2'd1,
      PRESSED   = 2'd2,
      RELEASING = 2'd3
   } btn_state_t;

   // $clog2(max(delay, period) + 1), never less than one bit so the counter
   // declaration stays legal when auto-repeat is disabled.
   function automatic int rep_ctr_width(input int delay, input int period);
      int max_val;
      max_val = (delay > period) ? delay : period;
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One push-button conditioner: synchroniser, press/release debounce FSM and
// optional auto-repeat generator.
//
// Parameters
//   CTR_WIDTH     : debounce counter width, interval is 2^CTR_WIDTH cycles
//   SYNC_STAGES   : synchroniser depth (>= 2)
//   ACTIVE_LOW    : 1 = low pin level means pressed
//   REPEAT_DELAY  : cycles from press pulse to first repeat, 0 disables repeat
//   REPEAT_PERIOD : cycles between later repeat pulses (>= 1)
//
// Ports
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   i_btn     in  raw asynchronous pin
//   o_level   out debounced pressed state
//   o_press   out one-cycle pulse on level rise
//   o_release out one-cycle pulse on level fall
//   o_repeat  out one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int CTR_WIDTH     = 20,
   parameter int SYNC_STAGES   = 2,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   // Pin level that means "not pressed"; the synchroniser powers up here so
   // leaving reset never looks like an edge.
   localparam logic INACTIVE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

   // ---------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{INACTIVE_PIN}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      end
   end

   // Polarity is normalised after the chain so the FSM always sees 1=pressed.
   assign w_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

   // ---------------------------------------------------------------------
   // Debounce FSM: state register
   // ---------------------------------------------------------------------
   btn_state_t           r_state;
   btn_state_t           w_state_next;
   logic [CTR_WIDTH-1:0] r_ctr;
   logic [CTR_WIDTH-1:0] w_ctr_next;
   logic                 w_press_evt;
   logic                 w_release_evt;
   logic                 w_repeat_evt;
   logic                 w_level_next;

   logic r_level;
   logic r_press;
   logic r_release;
   logic r_repeat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RELEASED;
         r_ctr     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_ctr     <= w_ctr_next;
         r_level   <= w_level_next;
         r_press   <= w_press_evt;
         r_release <= w_release_evt;
         r_repeat  <= w_repeat_evt;
      end
   end

   // ---------------------------------------------------------------------
   // Debounce FSM: next-state logic
   // The counter only runs in the two qualifying states and is cleared on
   // every state change, so it saturates through the transition instead of
   // wrapping.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_ctr_next    = r_ctr;
      w_press_evt   = 1'b0;
      w_release_evt = 1'b0;
      case (r_state)
         RELEASED: begin
            if (w_s) begin
               w_state_next = PRESSING;
               w_ctr_next   = '0;
            end
         end
         PRESSING: begin
            if (!w_s) begin
               w_state_next = RELEASED;
               w_ctr_next   = '0;
            end else if (r_ctr == '1) begin
               w_state_next = PRESSED;
               w_ctr_next   = '0;
               w_press_evt  = 1'b1;
            end else begin
               w_ctr_next   = r_ctr + 1'b1;
            end
         end
         PRESSED: begin
            if (!w_s) begin
               w_state_next = RELEASING;
               w_ctr_next   = '0;
            end
         end
         RELEASING: begin
            if (w_s) begin
               // Release glitch: back to held, no pulse.
               w_state_next = PRESSED;
               w_ctr_next   = '0;
            end else if (r_ctr == '1) begin
               w_state_next  = RELEASED;
               w_ctr_next    = '0;
               w_release_evt = 1'b1;
            end else begin
               w_ctr_next    = r_ctr + 1'b1;
            end
         end
         default: begin
            w_state_next = RELEASED;
            w_ctr_next   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Debounce FSM: output logic
   // Level is derived from the next state so the registered level moves on
   // the same edge as the registered press/release pulse.
   // ---------------------------------------------------------------------
   always_comb begin
      w_level_next = 1'b0;
      if ((w_state_next == PRESSED) || (w_state_next == RELEASING)) begin
         w_level_next = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Auto-repeat
   // ---------------------------------------------------------------------
   generate
      if (REPEAT_DELAY > 0) begin : g_repeat
         localparam int REP_W = rep_ctr_width(REPEAT_DELAY, REPEAT_PERIOD);
         localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
         localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

         logic [REP_W-1:0] r_rep_ctr;
         logic             r_rep_first;
         logic [REP_W-1:0] w_rep_target;
         logic             w_hold;

         // Counting only happens while genuinely held; RELEASING (and the
         // edge that enters it) leaves the counter frozen.
         assign w_hold       = (r_state == PRESSED) && w_s;
         assign w_rep_target = r_rep_first ? DELAY_LAST : PERIOD_LAST;
         assign w_repeat_evt = w_hold && (r_rep_ctr == w_rep_target);

         // After each pulse the counter restarts from zero against the
         // period target, so it never has to count past max(delay, period).
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rep_ctr   <= '0;
               r_rep_first <= 1'b1;
            end else if (w_press_evt) begin
               r_rep_ctr   <= '0;
               r_rep_first <= 1'b1;
            end else if (w_repeat_evt) begin
               r_rep_ctr   <= '0;
               r_rep_first <= 1'b0;
            end else if (w_hold) begin
               r_rep_ctr   <= r_rep_ctr + 1'b1;
            end
         end
      end else begin : g_no_repeat
         assign w_repeat_evt = 1'b0;
      end
   endgenerate

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// multi_button_debouncer
// N independent push-button conditioners behind one instance. Each channel
// synchronises its pin, debounces press and release, and emits a stable level
// plus single-cycle press, release and auto-repeat pulses.
//
// Parameters
//   NUM_BTN       : number of channels
//   CTR_WIDTH     : debounce counter width, interval is 2^CTR_WIDTH cycles
//   SYNC_STAGES   : synchroniser depth (>= 2)
//   ACTIVE_LOW    : 1 = low pin level means pressed
//   REPEAT_DELAY  : cycles from press pulse to first repeat, 0 disables repeat
//   REPEAT_PERIOD : cycles between later repeat pulses (>= 1)
//
// Ports
//   clk       in  clock for all logic
//   rst       in  synchronous active-high reset
//   i_btn     in  [NUM_BTN] raw asynchronous pins
//   o_level   out [NUM_BTN] debounced pressed state
//   o_press   out [NUM_BTN] press pulses
//   o_release out [NUM_BTN] release pulses
//   o_repeat  out [NUM_BTN] auto-repeat pulses
// -----------------------------------------------------------------------------
module multi_button_debouncer
   import button_pkg::*;
#(
   parameter int NUM_BTN       = 4,
   parameter int CTR_WIDTH     = 20,
   parameter int SYNC_STAGES   = 2,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_repeat
);

   // Channels share nothing but clock and reset.
   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
         button_channel #(
            .CTR_WIDTH     (CTR_WIDTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
         ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (i_btn[gi]),
            .o_level   (o_level[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi]),
            .o_repeat  (o_repeat[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// Bench for multi_button_debouncer. Two instances share clock and reset:
//   A: active-high pins, auto-repeat delay 8 / period 4
//   B: active-low pins, auto-repeat off
// The reference model tracks, per channel, the pin history seen through the
// synchroniser and the length of the current run of samples disagreeing with
// the debounced level; the level flips once that run reaches 2^CTR_WIDTH+1
// samples. Repeats come from the elapsed held time since the press.
// -----------------------------------------------------------------------------
module tb_multi_button_debouncer;

   localparam int NB      = 4;
   localparam int CW      = 4;
   localparam int SS      = 2;
   localparam int RUN_LEN = (1 << CW) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_a, btn_b;
   logic [NB-1:0] lvl_a, prs_a, rel_a, rep_a;
   logic [NB-1:0] lvl_b, prs_b, rel_b, rep_b;

   always #5 clk = ~clk;

   multi_button_debouncer #(
      .NUM_BTN(NB), .CTR_WIDTH(CW), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b0),
      .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) dut_a (
      .clk(clk), .rst(rst), .i_btn(btn_a),
      .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_repeat(rep_a)
   );

   multi_button_debouncer #(
      .NUM_BTN(NB), .CTR_WIDTH(CW), .SYNC_STAGES(SS), .ACTIVE_LOW(1'b1),
      .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
   ) dut_b (
      .clk(clk), .rst(rst), .i_btn(btn_b),
      .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_repeat(rep_b)
   );

   // ---------------- reference model ----------------
   int   m_al  [2] = '{0, 1};
   int   m_rd  [2] = '{8, 0};
   int   m_rp  [2] = '{4, 1};
   bit   m_hist[2][NB][SS];   // s values in flight through the synchroniser
   int   m_run [2][NB];
   int   m_hold[2][NB];
   bit   m_lvl [2][NB];
   logic [NB-1:0] e_lvl[2], e_prs[2], e_rel[2], e_rep[2];

   always @(posedge clk) begin
      bit pin, s;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NB; c++) begin
            pin = (d == 0) ? btn_a[c] : btn_b[c];
            e_prs[d][c] = 1'b0;
            e_rel[d][c] = 1'b0;
            e_rep[d][c] = 1'b0;
            if (rst) begin
               for (int k = 0; k < SS; k++) m_hist[d][c][k] = 1'b0;
               m_run[d][c]  = 0;
               m_hold[d][c] = 0;
               m_lvl[d][c]  = 1'b0;
            end else begin
               s = m_hist[d][c][SS-1];
               for (int k = SS-1; k > 0; k--) m_hist[d][c][k] = m_hist[d][c][k-1];
               m_hist[d][c][0] = (m_al[d] != 0) ? ~pin : pin;
               if (s != m_lvl[d][c]) begin
                  m_run[d][c]++;
                  if (m_run[d][c] == RUN_LEN) begin
                     m_lvl[d][c] = s;
                     m_run[d][c] = 0;
                     if (s) begin
                        e_prs[d][c]  = 1'b1;
                        m_hold[d][c] = 0;
                     end else begin
                        e_rel[d][c]  = 1'b1;
                     end
                  end
               end else begin
                  // Held with no pending release: time since press advances.
                  if (m_lvl[d][c] && m_run[d][c] == 0 && m_rd[d] > 0) begin
                     m_hold[d][c]++;
                     if (m_hold[d][c] >= m_rd[d] &&
                         ((m_hold[d][c] - m_rd[d]) % m_rp[d]) == 0)
                        e_rep[d][c] = 1'b1;
                  end
                  m_run[d][c] = 0;
               end
            end
            e_lvl[d][c] = m_lvl[d][c];
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      chk("A.level",   lvl_a, e_lvl[0]);
      chk("A.press",   prs_a, e_prs[0]);
      chk("A.release", rel_a, e_rel[0]);
      chk("A.repeat",  rep_a, e_rep[0]);
      chk("B.level",   lvl_b, e_lvl[1]);
      chk("B.press",   prs_b, e_prs[1]);
      chk("B.release", rel_b, e_rel[1]);
      chk("B.repeat",  rep_b, e_rep[1]);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".lvl_a"}, lvl_a, '0);
      chk({tag, ".prs_a"}, prs_a, '0);
      chk({tag, ".rel_a"}, rel_a, '0);
      chk({tag, ".rep_a"}, rep_a, '0);
      chk({tag, ".lvl_b"}, lvl_b, '0);
      chk({tag, ".prs_b"}, prs_b, '0);
      chk({tag, ".rel_b"}, rel_b, '0);
      chk({tag, ".rep_b"}, rep_b, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit found;
      int len;

      rst   = 1'b1;
      btn_a = '0;
      btn_b = '1;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // Active-low pins idling high must never look pressed.
      repeat (40) begin
         tick();
         chk("al_idle.level_b", lvl_b, '0);
      end

      // Clean press on channel 0: 18 edges of latency after the pin change.
      btn_a[0] = 1'b1;
      repeat (18) tick();
      chk("clean.press_early", prs_a, '0);
      chk("clean.level_early", lvl_a, '0);
      tick();
      chk("clean.press", prs_a, 4'b0001);
      chk("clean.level", lvl_a, 4'b0001);
      tick();
      chk("clean.press_once", prs_a, '0);

      // Bounce on channel 1: toggles every 5 cycles, then random short glitches.
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0) btn_a[1] = ~btn_a[1];
         tick();
         chk("bounce.no_press", prs_a & 4'b0010, '0);
      end
      btn_a[1] = 1'b1;
      repeat (18) tick();
      chk("bounce.press_early", prs_a & 4'b0010, '0);
      tick();
      chk("bounce.press", prs_a & 4'b0010, 4'b0010);

      for (int g = 0; g < 8; g++) begin
         btn_a[1] = ~btn_a[1];
         len = $urandom_range(1, 14);
         repeat (len) begin
            tick();
            chk("bounce.no_release", rel_a & 4'b0010, '0);
         end
      end
      btn_a[1] = 1'b1;
      repeat (20) tick();
      chk("bounce.still_held", lvl_a & 4'b0010, 4'b0010);

      // Release glitch of 3 cycles on channel 0 leaves the level high.
      btn_a[0] = 1'b0;
      repeat (3) tick();
      btn_a[0] = 1'b1;
      repeat (25) begin
         tick();
         chk("glitch.level0",   lvl_a & 4'b0001, 4'b0001);
         chk("glitch.release0", rel_a & 4'b0001, '0);
      end

      // Clean release on channel 0.
      btn_a[0] = 1'b0;
      repeat (18) tick();
      chk("release.early", rel_a & 4'b0001, '0);
      tick();
      chk("release.pulse", rel_a & 4'b0001, 4'b0001);
      chk("release.level", lvl_a & 4'b0001, '0);

      // Auto-repeat on channel 2: pulses at P+8, P+12, P+16.
      btn_a[2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (prs_a[2]) found = 1'b1;
      end
      chk("rep.press_seen", {3'b0, found}, 4'b0001);
      for (int j = 1; j <= 16; j++) begin
         tick();
         chk("rep.pulse", {3'b0, rep_a[2]},
             {3'b0, (j == 8 || j == 12 || j == 16)});
      end
      btn_a[2] = 1'b0;
      found = 1'b0;
      repeat (25) begin
         tick();
         chk("rep.after_release", rep_a & 4'b0100, '0);
         if (rel_a[2]) found = 1'b1;
      end
      chk("rep.release_seen", {3'b0, found}, 4'b0001);

      // Random pin activity on both instances, checked against the model.
      repeat (600) begin
         for (int c = 0; c < NB; c++) begin
            if ($urandom_range(0, 9) == 0) btn_a[c] = ~btn_a[c];
            if ($urandom_range(0, 9) == 0) btn_b[c] = ~btn_b[c];
         end
         tick();
      end

      // Active-low channel 3 held, reset mid-press, then re-qualification.
      btn_a = '0;
      btn_b = '1;
      repeat (40) tick();
      chk("settle.level_b", lvl_b, '0);
      btn_b[3] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (lvl_b[3]) found = 1'b1;
      end
      chk("al.press_seen", {3'b0, found}, 4'b0001);
      rst = 1'b1;
      tick();
      chk_all_zero("mid_reset");
      rst = 1'b0;
      repeat (18) tick();
      chk("al.repress_early", prs_b, '0);
      tick();
      chk("al.repress", prs_b, 4'b1000);
      chk("al.relevel", lvl_b, 4'b1000);
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
